// File: rtl/regfile_seq_if.sv
// Command handshake between a host and the register-pair sequencer:
// valid/ready command transfer plus the completion and error pulses.
interface regfile_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_pair;
  logic       done;
  logic       err;

  modport master (output cmd_valid, cmd_op, cmd_pair, input cmd_ready, done, err);
  modport slave  (input cmd_valid, cmd_op, cmd_pair, output cmd_ready, done, err);
endinterface

// File: rtl/regfile_seq.sv
// Command sequencer for the 16-bit register-pair file: turns one accepted command
// into an ordered, registered sequence of pair selects, incdec mode bits and strobes.
module regfile_seq #(
  parameter int unsigned STROBE_W   = 1,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_seq_if.slave cmd,
  output logic         bc_rw_o,
  output logic         de_rw_o,
  output logic         hl_rw_o,
  output logic         wz_rw_o,
  output logic         pc_rw_o,
  output logic         sp_rw_o,
  output logic         rreg_rd_o,
  output logic         lreg_rd_o,
  output logic         rreg_wr_o,
  output logic         lreg_wr_o,
  output logic         dreg_rd_o,
  output logic         dreg_wr_o,
  output logic         dreg_inc_o,
  output logic         dreg_dec_o,
  output logic         dreg_cnt_o,
  output logic         dreg_cnt2_o
);

  if (STROBE_W < 1 || STROBE_W > 4) begin : g_bad_strobe_w
    $fatal(1, "regfile_seq: STROBE_W must be in 1..4");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 4) begin : g_bad_settle_cyc
    $fatal(1, "regfile_seq: SETTLE_CYC must be in 1..4");
  end

  localparam logic [1:0] STROBE_LAST = 2'(STROBE_W - 1);
  localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYC - 1);

  localparam logic [2:0] OP_RD_LO = 3'd4;
  localparam logic [2:0] OP_RD_HI = 3'd5;
  localparam logic [2:0] OP_WR_LO = 3'd6;
  localparam logic [2:0] OP_WR_HI = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LATCH, S_SETTLE, S_STROBE, S_HOLD, S_ERR
  } state_e;

  // Every output is a flop so the register file never sees a decode glitch.
  typedef struct packed {
    logic       ready;
    logic       done;
    logic       err;
    logic [5:0] sel;      // {sp, pc, wz, hl, de, bc}
    logic       rreg_rd;
    logic       lreg_rd;
    logic       rreg_wr;
    logic       lreg_wr;
    logic       dreg_rd;
    logic       dreg_wr;
    logic       inc;
    logic       dec;
    logic       cnt;
    logic       cnt2;
  } out_t;

  localparam out_t OUT_RST = '{ready: 1'b1, default: '0};

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [2:0] pair_q, pair_d;
  out_t       out_q, out_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    pair_d  = pair_q;
    case (state_q)
      S_IDLE: begin
        // cmd_ready is high exactly while IDLE, so valid alone completes the transfer.
        if (cmd.cmd_valid) begin
          op_d    = cmd.cmd_op;
          pair_d  = cmd.cmd_pair;
          state_d = (cmd.cmd_pair > 3'd5) ? S_ERR : S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = STROBE_LAST;
        state_d = op_q[2] ? S_STROBE : S_LATCH;
      end
      S_LATCH: begin
        if (cnt_q == '0) begin
          cnt_d   = SETTLE_LAST;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          cnt_d   = STROBE_LAST;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) state_d = S_HOLD;
        else             cnt_d   = cnt_q - 2'd1;
      end
      S_HOLD:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state, then registered alongside it.
  always_comb begin
    out_d       = '0;
    out_d.ready = (state_d == S_IDLE);
    out_d.done  = (state_d == S_HOLD) || (state_d == S_ERR);
    out_d.err   = (state_d == S_ERR);
    if (state_d inside {S_SETUP, S_LATCH, S_SETTLE, S_STROBE, S_HOLD}) begin
      out_d.sel = 6'b000001 << pair_d;
      if (!op_d[2]) begin
        out_d.inc  = !op_d[0];
        out_d.dec  =  op_d[0];
        out_d.cnt  = !op_d[1];
        out_d.cnt2 =  op_d[1];
      end
    end
    out_d.dreg_rd = (state_d == S_LATCH);
    if (state_d == S_STROBE) begin
      case (op_d)
        OP_RD_LO: out_d.rreg_rd = 1'b1;
        OP_RD_HI: out_d.lreg_rd = 1'b1;
        OP_WR_LO: out_d.rreg_wr = 1'b1;
        OP_WR_HI: out_d.lreg_wr = 1'b1;
        default:  out_d.dreg_wr = 1'b1;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      pair_q  <= '0;
      out_q   <= OUT_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      pair_q  <= pair_d;
      out_q   <= out_d;
    end
  end

  assign cmd.cmd_ready = out_q.ready;
  assign cmd.done      = out_q.done;
  assign cmd.err       = out_q.err;
  assign bc_rw_o       = out_q.sel[0];
  assign de_rw_o       = out_q.sel[1];
  assign hl_rw_o       = out_q.sel[2];
  assign wz_rw_o       = out_q.sel[3];
  assign pc_rw_o       = out_q.sel[4];
  assign sp_rw_o       = out_q.sel[5];
  assign rreg_rd_o     = out_q.rreg_rd;
  assign lreg_rd_o     = out_q.lreg_rd;
  assign rreg_wr_o     = out_q.rreg_wr;
  assign lreg_wr_o     = out_q.lreg_wr;
  assign dreg_rd_o     = out_q.dreg_rd;
  assign dreg_wr_o     = out_q.dreg_wr;
  assign dreg_inc_o    = out_q.inc;
  assign dreg_dec_o    = out_q.dec;
  assign dreg_cnt_o    = out_q.cnt;
  assign dreg_cnt2_o   = out_q.cnt2;

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: per-cycle output timelines from phase lengths, plus a
// strobe-driven register-file consumer checked against plain pair arithmetic.
module tb_regfile_seq;
  localparam int SW_B = 3;
  localparam int SC_B = 2;

  typedef struct packed {
    logic       ready;
    logic       done;
    logic       err;
    logic [5:0] sel;
    logic       rreg_rd;
    logic       lreg_rd;
    logic       rreg_wr;
    logic       lreg_wr;
    logic       dreg_rd;
    logic       dreg_wr;
    logic       inc;
    logic       dec;
    logic       cnt;
    logic       cnt2;
  } obs_t;

  localparam obs_t RST_OBS = '{ready: 1'b1, default: '0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_seq_if ifa ();
  regfile_seq_if ifb ();

  logic [5:0] sel_a, sel_b, stb_a, stb_b;
  logic [3:0] mode_a, mode_b;
  obs_t       obs_a, obs_b;

  assign obs_a = {ifa.cmd_ready, ifa.done, ifa.err, sel_a, stb_a, mode_a};
  assign obs_b = {ifb.cmd_ready, ifb.done, ifb.err, sel_b, stb_b, mode_b};

  regfile_seq dut_a (
    .clk(clk), .rst(rst), .cmd(ifa),
    .bc_rw_o(sel_a[0]), .de_rw_o(sel_a[1]), .hl_rw_o(sel_a[2]),
    .wz_rw_o(sel_a[3]), .pc_rw_o(sel_a[4]), .sp_rw_o(sel_a[5]),
    .rreg_rd_o(stb_a[5]), .lreg_rd_o(stb_a[4]), .rreg_wr_o(stb_a[3]),
    .lreg_wr_o(stb_a[2]), .dreg_rd_o(stb_a[1]), .dreg_wr_o(stb_a[0]),
    .dreg_inc_o(mode_a[3]), .dreg_dec_o(mode_a[2]),
    .dreg_cnt_o(mode_a[1]), .dreg_cnt2_o(mode_a[0])
  );

  regfile_seq #(.STROBE_W(SW_B), .SETTLE_CYC(SC_B)) dut_b (
    .clk(clk), .rst(rst), .cmd(ifb),
    .bc_rw_o(sel_b[0]), .de_rw_o(sel_b[1]), .hl_rw_o(sel_b[2]),
    .wz_rw_o(sel_b[3]), .pc_rw_o(sel_b[4]), .sp_rw_o(sel_b[5]),
    .rreg_rd_o(stb_b[5]), .lreg_rd_o(stb_b[4]), .rreg_wr_o(stb_b[3]),
    .lreg_wr_o(stb_b[2]), .dreg_rd_o(stb_b[1]), .dreg_wr_o(stb_b[0]),
    .dreg_inc_o(mode_b[3]), .dreg_dec_o(mode_b[2]),
    .dreg_cnt_o(mode_b[1]), .dreg_cnt2_o(mode_b[0])
  );

  int n_vec = 0;
  int n_bad = 0;

  // Register file reacting to dut_a strobe rising edges, and the arithmetic model.
  logic [15:0] rf     [6];
  logic [15:0] exp_rf [6];
  logic [15:0] rf_latch;
  logic [7:0]  data_in, data_out;
  obs_t        prev_a;
  int          wr_rises = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic int cmd_len(input logic [2:0] op, input logic [2:0] pair, input int sw, input int sc);
    if (pair > 3'd5) return 1;
    if (op < 3'd4)   return 2 + 2 * sw + sc;
    return 2 + sw;
  endfunction

  // Expected outputs k cycles after the accept cycle, from the phase lengths.
  function automatic obs_t exp_out(input logic [2:0] op, input logic [2:0] pair, input int k,
                                   input int sw, input int sc);
    obs_t e;
    int   hold, lat_s, lat_e, str_s, str_e;
    e    = '0;
    hold = cmd_len(op, pair, sw, sc);
    if (k > hold) begin
      e.ready = 1'b1;
      return e;
    end
    if (pair > 3'd5) begin
      e.done = 1'b1;
      e.err  = 1'b1;
      return e;
    end
    if (op < 3'd4) begin
      lat_s = 2; lat_e = 1 + sw; str_s = lat_e + sc + 1;
    end else begin
      lat_s = 0; lat_e = -1; str_s = 2;
    end
    str_e = str_s + sw - 1;
    e.sel[pair] = 1'b1;
    if (op < 3'd4) begin
      e.inc  = !op[0];
      e.dec  =  op[0];
      e.cnt  = !op[1];
      e.cnt2 =  op[1];
    end
    e.dreg_rd = (k >= lat_s) && (k <= lat_e);
    if (k >= str_s && k <= str_e) begin
      case (op)
        3'd4:    e.rreg_rd = 1'b1;
        3'd5:    e.lreg_rd = 1'b1;
        3'd6:    e.rreg_wr = 1'b1;
        3'd7:    e.lreg_wr = 1'b1;
        default: e.dreg_wr = 1'b1;
      endcase
    end
    e.done = (k == hold);
    return e;
  endfunction

  function automatic logic inv_bad(input obs_t o);
    logic [5:0] stb;
    stb = {o.rreg_rd, o.lreg_rd, o.rreg_wr, o.lreg_wr, o.dreg_rd, o.dreg_wr};
    return ($countones(o.sel) > 1) || ($countones(stb) > 1) ||
           ((o.rreg_rd || o.lreg_rd || o.dreg_rd) && (o.rreg_wr || o.lreg_wr || o.dreg_wr)) ||
           (o.inc && o.dec) || (o.cnt && o.cnt2);
  endfunction

  task automatic rf_step();
    int          idx;
    logic [15:0] step;
    idx  = -1;
    step = obs_a.cnt2 ? 16'd2 : 16'd1;
    for (int i = 0; i < 6; i++) if (obs_a.sel[i]) idx = i;
    if (obs_a.dreg_wr && !prev_a.dreg_wr) wr_rises++;
    if (idx >= 0) begin
      if (obs_a.dreg_rd && !prev_a.dreg_rd) rf_latch = rf[idx];
      if (obs_a.dreg_wr && !prev_a.dreg_wr)
        rf[idx] = obs_a.inc ? rf_latch + step : (obs_a.dec ? rf_latch - step : rf_latch);
      if (obs_a.rreg_rd && !prev_a.rreg_rd) data_out = rf[idx][7:0];
      if (obs_a.lreg_rd && !prev_a.lreg_rd) data_out = rf[idx][15:8];
      if (obs_a.rreg_wr && !prev_a.rreg_wr) rf[idx][7:0]  = data_in;
      if (obs_a.lreg_wr && !prev_a.lreg_wr) rf[idx][15:8] = data_in;
    end
    prev_a = obs_a;
  endtask

  // Every sample point: falling edge, feed the register file, check invariants.
  task automatic tick();
    @(negedge clk);
    rf_step();
    check("inv_a", 32'(inv_bad(obs_a)), 0);
    check("inv_b", 32'(inv_bad(obs_b)), 0);
  endtask

  task automatic drive(input bit use_b, input logic v, input logic [2:0] op, input logic [2:0] pair);
    if (use_b) begin
      ifb.cmd_valid = v; ifb.cmd_op = op; ifb.cmd_pair = pair; ifa.cmd_valid = 1'b0;
    end else begin
      ifa.cmd_valid = v; ifa.cmd_op = op; ifa.cmd_pair = pair; ifb.cmd_valid = 1'b0;
    end
  endtask

  // Called at a sample point; issues one command and checks every cycle through
  // the first IDLE cycle after it. With chain set, valid stays high carrying nop/npair.
  task automatic run_cmd(input bit use_b, input logic [2:0] op, input logic [2:0] pair,
                         input bit chain, input logic [2:0] nop, input logic [2:0] npair);
    int   sw, sc, len;
    obs_t o;
    sw = use_b ? SW_B : 1;
    sc = use_b ? SC_B : 1;
    drive(use_b, 1'b1, op, pair);
    for (int i = 0; i < 32; i++) begin
      if (use_b ? ifb.cmd_ready : ifa.cmd_ready) break;
      tick();
    end
    check("accept_ready", 32'(use_b ? ifb.cmd_ready : ifa.cmd_ready), 1);
    @(posedge clk);
    #1;
    if (chain) drive(use_b, 1'b1, nop, npair);
    else       drive(use_b, 1'b0, 3'($urandom), 3'($urandom));
    len = cmd_len(op, pair, sw, sc);
    for (int k = 1; k <= len + 1; k++) begin
      tick();
      o = use_b ? obs_b : obs_a;
      check($sformatf("%s_op%0d_p%0d_k%0d", use_b ? "b" : "a", op, pair, k), o,
            exp_out(op, pair, k, sw, sc));
    end
  endtask

  task automatic cmd_a(input logic [2:0] op, input logic [2:0] pair, input logic [7:0] d,
                       input bit chain, input logic [2:0] nop, input logic [2:0] npair);
    logic [7:0] rd;
    rd = '0;
    if (pair <= 3'd5) begin
      case (op)
        3'd0: exp_rf[pair] = exp_rf[pair] + 16'd1;
        3'd1: exp_rf[pair] = exp_rf[pair] - 16'd1;
        3'd2: exp_rf[pair] = exp_rf[pair] + 16'd2;
        3'd3: exp_rf[pair] = exp_rf[pair] - 16'd2;
        3'd4: rd = exp_rf[pair][7:0];
        3'd5: rd = exp_rf[pair][15:8];
        3'd6: exp_rf[pair][7:0]  = d;
        default: exp_rf[pair][15:8] = d;
      endcase
    end
    data_in  = d;
    data_out = ~rd;
    run_cmd(1'b0, op, pair, chain, nop, npair);
    if (pair <= 3'd5) check($sformatf("rf_p%0d", pair), rf[pair], exp_rf[pair]);
    if (pair <= 3'd5 && (op == 3'd4 || op == 3'd5)) check("rd_data", data_out, rd);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want summary");
    $fatal(1);
  end

  initial begin
    logic [2:0] cop, cpair, nop, npair;
    int         wr0;
    bit         ch;

    ifa.cmd_op = '0; ifa.cmd_pair = '0;
    ifb.cmd_op = '0; ifb.cmd_pair = '0;
    drive(1'b0, 1'b0, 3'd0, 3'd0);
    data_in = '0; data_out = '0; rf_latch = '0; prev_a = '0;
    for (int i = 0; i < 6; i++) begin rf[i] = '0; exp_rf[i] = '0; end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("rst_a", obs_a, RST_OBS);
    check("rst_b", obs_b, RST_OBS);

    // Reset while INC1 on BC is in LATCH: outputs clear, no write-back ever.
    rf[0] = 16'h5738; exp_rf[0] = 16'h5738;
    wr0 = wr_rises;
    drive(1'b0, 1'b1, 3'd0, 3'd0);
    check("t1_ready", 32'(ifa.cmd_ready), 1);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 3'd0, 3'd0);
    tick();
    check("t1_setup_sel", obs_a.sel, 6'b000001);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    check("t1_latch", 32'(obs_a.dreg_rd), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("t1_rst_out", obs_a, RST_OBS);
    repeat (4) begin
      tick();
      check("t1_idle", obs_a, RST_OBS);
    end
    check("t1_no_wr", wr_rises, wr0);
    check("t1_bc", rf[0], 16'h5738);

    cmd_a(3'd0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
    check("t2_bc", rf[0], 16'h5739);

    rf[5] = 16'h0001; exp_rf[5] = 16'h0001;
    cmd_a(3'd3, 3'd5, 8'h00, 1'b0, 3'd0, 3'd0);
    check("t3_sp_wrap", rf[5], 16'hFFFF);

    rf[1] = 16'h12AA; exp_rf[1] = 16'h12AA;
    cmd_a(3'd7, 3'd1, 8'hC3, 1'b0, 3'd0, 3'd0);
    check("t4_de", rf[1], 16'hC3AA);

    rf[4] = 16'h0100; exp_rf[4] = 16'h0100;
    cmd_a(3'd4, 3'd4, 8'h00, 1'b0, 3'd0, 3'd0);
    check("t5_pc_lo", data_out, 8'h00);
    run_cmd(1'b1, 3'd4, 3'd4, 1'b0, 3'd0, 3'd0);

    // Illegal pair, then back-to-back commands with valid held high throughout.
    cmd_a(3'd2, 3'd6, 8'h00, 1'b1, 3'd0, 3'd2);
    cmd_a(3'd0, 3'd2, 8'h00, 1'b1, 3'd1, 3'd3);
    cmd_a(3'd1, 3'd3, 8'h00, 1'b1, 3'd5, 3'd7);
    cmd_a(3'd5, 3'd7, 8'h00, 1'b0, 3'd0, 3'd0);

    for (int i = 0; i < 6; i++) begin
      rf[i] = 16'($urandom);
      exp_rf[i] = rf[i];
    end
    cop = 3'($urandom); cpair = 3'($urandom);
    for (int n = 0; n < 30; n++) begin
      nop = 3'($urandom); npair = 3'($urandom);
      ch  = (n != 29) && ($urandom_range(0, 1) == 1);
      cmd_a(cop, cpair, 8'($urandom), ch, nop, npair);
      cop = nop; cpair = npair;
    end
    for (int n = 0; n < 15; n++) begin
      nop = 3'($urandom); npair = 3'($urandom);
      ch  = (n != 14) && ($urandom_range(0, 1) == 1);
      run_cmd(1'b1, cop, cpair, ch, nop, npair);
      cop = nop; cpair = npair;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
